// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive framer with 16x oversampling, glitch rejection, framing-error and break detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  output logic             rx_done_tick,
  output logic [DBITS-1:0] dout,
  output logic             frame_err,
  output logic             break_det
`ifdef UART_RX_PARITY_EN
  , output logic           parity_err
`endif
);

  localparam logic [2:0] LAST_BIT  = 3'(DBITS - 1);
  // Stop bits beyond the first are counted in whole bit periods on n_cnt.
  localparam logic [2:0] LAST_STOP = 3'(SB_TICK / OVERSAMPLE - 1);

  logic             rx_s;
  rx_state_e        state, state_next;
  logic [3:0]       s_cnt, s_cnt_next;
  logic [2:0]       n_cnt, n_cnt_next;
  logic [DBITS-1:0] b_reg, b_next, dout_next;
  logic             done_next, ferr_next, brk_next;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_next, perr_next;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk_100MHz),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n_cnt        <= n_cnt_next;
      b_reg        <= b_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      frame_err    <= ferr_next;
      break_det    <= brk_next;
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_next;
      parity_err   <= perr_next;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_next     = b_reg;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    brk_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    perr_next    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_TICK) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              s_cnt_next = '0;
              n_cnt_next = '0;
            end
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          s_cnt_next = s_cnt + 4'd1;
          if (s_cnt == LAST_TICK) begin
            b_next = {rx_s, b_reg[DBITS-1:1]};
            if (n_cnt == LAST_BIT) begin
              n_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_cnt_next = n_cnt + 3'd1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          s_cnt_next = s_cnt + 4'd1;
          if (s_cnt == LAST_TICK) begin
            par_bad_next = ^{b_reg, rx_s};
            state_next   = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          s_cnt_next = s_cnt + 4'd1;
          if (s_cnt == LAST_TICK && n_cnt == LAST_STOP) begin
            n_cnt_next = '0;
            if (rx_s) begin
              done_next  = 1'b1;
              dout_next  = b_reg;
`ifdef UART_RX_PARITY_EN
              perr_next  = par_bad;
`endif
              state_next = IDLE;
            end else begin
              ferr_next  = 1'b1;
              brk_next   = (b_reg == '0);
              state_next = WAIT_HIGH;
            end
          end else if (s_cnt == LAST_TICK) begin
            n_cnt_next = n_cnt + 3'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int DBITS   = 8;
  localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edge is driven just after a tick; the next tick is lost to the synchroniser,
  // so the start midpoint is tick 9 and each later bit adds 16.
  localparam int STOP_DELAY = 9 + 16 * (DBITS + PBITS + 1);

  logic             clk_100MHz = 1'b0;
  logic             reset      = 1'b1;
  logic             rx         = 1'b1;
  logic             s_tick     = 1'b0;
  logic             rx_done_tick, frame_err, break_det, parity_err;
  logic [DBITS-1:0] dout;

  typedef struct {
    bit         good;
    logic [7:0] data;
    bit         brk;
    bit         perr;
    int         tick;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         tick_no   = 0;
  logic [7:0] last_good = '0;

  uart_rx_sampler #(.DBITS(DBITS), .SB_TICK(SB_TICK)) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .break_det    (break_det)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      @(negedge clk_100MHz) s_tick = 1'b1;
      tick_no++;
      @(negedge clk_100MHz) s_tick = 1'b0;
      repeat (2) @(negedge clk_100MHz);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    run_ticks(16);
  endtask

  // Model: a good stop yields the byte; a low stop yields a framing error
  // (plus break when the data is zero) and leaves dout at the last good byte.
  task automatic send_frame(input logic [7:0] data, input logic stop_v, input logic par_flip);
    exp_t e;
    e.good = stop_v;
    e.data = stop_v ? data : last_good;
    e.brk  = !stop_v && (data == 8'h00);
    e.perr = stop_v && (PBITS != 0) && par_flip;
    e.tick = tick_no + STOP_DELAY;
    if (stop_v) last_good = data;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DBITS; i++) drive_bit(data[i]);
    if (PBITS != 0) drive_bit((^data) ^ par_flip);
    drive_bit(stop_v);
  endtask

  task automatic pulse_reset();
    @(negedge clk_100MHz) reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    reset     = 1'b0;
    last_good = '0;
  endtask

  task automatic idle_and_drain(input string tag, input int n);
    rx = 1'b1;
    run_ticks(n);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every status pulse must match the next expected frame outcome.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_100MHz);
      if (!reset && (rx_done_tick || frame_err || break_det || parity_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({rx_done_tick, frame_err, break_det, parity_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_done_tick", 32'(rx_done_tick), 32'(e.good));
          check("frame_err", 32'(frame_err), 32'(!e.good));
          check("break_det", 32'(break_det), 32'(e.brk));
          check("dout", 32'(dout), 32'(e.data));
          check("latency_ticks", 32'(tick_no), 32'(e.tick));
`ifdef UART_RX_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    bit         bad, pf;
    int         gap;

    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    @(negedge clk_100MHz);
    check("reset_rx_done_tick", 32'(rx_done_tick), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_break_det", 32'(break_det), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    run_ticks(20);

    send_frame(8'h55, 1'b1, 1'b0);
    idle_and_drain("frame_55_missing", 16);

    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_and_drain("back_to_back_missing", 16);

    rx = 1'b0;
    run_ticks(3);
    idle_and_drain("glitch_pulse", 20);
    send_frame(8'h12, 1'b1, 1'b0);
    idle_and_drain("after_glitch_missing", 16);

    send_frame(8'h7E, 1'b0, 1'b0);
    idle_and_drain("frame_err_missing", 16);
    check("dout_kept_after_ferr", 32'(dout), 32'h12);

    send_frame(8'h00, 1'b0, 1'b0);
    rx = 1'b0;
    run_ticks(16 * (20 - (DBITS + PBITS + 2)));
    idle_and_drain("break_missing", 32);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_and_drain("after_break_missing", 16);

    // 0xF0 aborted by reset during data bit 4 (a high bit), rest of frame stays high.
    rx = 1'b0;
    run_ticks(16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    run_ticks(8);
    pulse_reset();
    run_ticks(8 + 16 * 4);
    check("dout_after_reset", 32'(dout), 32'd0);
    idle_and_drain("reset_abort_pulse", 16);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_and_drain("after_reset_missing", 16);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle_and_drain("parity_frame_missing", 16);
`endif

    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      pf  = ($urandom_range(0, 3) == 0);
      gap = int'($urandom_range(0, 3));
      if (bad && $urandom_range(0, 3) == 0) d = 8'h00;
      if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        run_ticks(int'($urandom_range(1, 5)));
        rx = 1'b1;
        run_ticks(16);
      end
      send_frame(d, !bad, pf);
      rx = 1'b1;
      if (bad) run_ticks(2 + gap * 16);
      else if (gap != 0) run_ticks(gap * 16);
    end
    idle_and_drain("random_missing", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial-to-parallel receive front end for the UART core: synchronises the raw `rx` pin and frames start/data/stop bits using the 16x oversampling tick from the baud-rate generator. Emits one byte per valid frame with a single-cycle strobe that drives the RX FIFO write port. Sits between the board pin and the RX FIFO inside `uart_top`. Adds glitch rejection, framing-error and break detection, and optional even parity.

## Interface
- `DBITS`, 8: data bits per frame, 5..8.
- `SB_TICK`, 16: oversampling ticks in the stop bit; 16 = 1 stop bit, 32 = 2 stop bits.
- `clk_100MHz`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  raw asynchronous serial line; idle high.
- `s_tick`  in  1  one-cycle pulse at 16x baud rate from the baud generator.
- `rx_done_tick`  out  1  one-cycle strobe; `dout` is valid this cycle. Connects to the FIFO write enable.
- `dout`  out  DBITS  received byte, LSB = first data bit.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `break_det`  out  1  one-cycle pulse when a frame is all-zero data and has a low stop bit.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. The port exists only under `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Tick counter `s_cnt` is 4 bits and counts only on `s_tick`. Bit counter `n_cnt` is 3 bits. Shift register `b_reg` is DBITS wide.
- IDLE:
  - `rx_s == 0` → START, and `s_cnt` clears.
- START:
  - On the `s_tick` where `s_cnt == 7` (mid start bit), check `rx_s`.
  - If `rx_s == 1`, the start bit was a glitch → IDLE, with no output.
  - Otherwise → DATA, and `s_cnt` and `n_cnt` clear.
- DATA:
  - On the `s_tick` where `s_cnt == 15`, shift `b_reg <= {rx_s, b_reg[DBITS-1:1]}`.
  - After DBITS bits → PARITY (macro set) or STOP.
- PARITY (macro only):
  - On the `s_tick` where `s_cnt == 15`, latch `par_bad = ^{b_reg, rx_s}` (even parity) → STOP.
- STOP:
  - On the `s_tick` where `s_cnt == SB_TICK-1`, evaluate `rx_s`.
  - `rx_s == 1`: pulse `rx_done_tick`, load `dout <= b_reg`, pulse `parity_err` if `par_bad` → IDLE.
  - `rx_s == 0`: pulse `frame_err`; also pulse `break_det` if `b_reg == 0`. `dout` is unchanged and there is no `rx_done_tick` → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s == 1` → IDLE. This prevents a held-low line from retriggering frames.
- A parity-error frame still asserts `rx_done_tick` and loads the byte; the error flag is advisory.
- `s_tick` arriving in IDLE or WAIT_HIGH is ignored.

## Timing
- Reset values: state = IDLE; `rx_done_tick`, `frame_err`, `break_det`, `parity_err` = 0; `dout` = 0; all counters and `b_reg` = 0.
- Reset mid-frame aborts the frame on the next edge. There is no output pulse and the partial byte is discarded.
- Pin-to-state latency is 2 cycles (synchroniser).
- For each frame, `rx_done_tick` rises 1 clock after the `s_tick` that samples the stop bit.
- With 16x ticks and `SB_TICK` = 16, the strobe occurs about (1 + DBITS + 1) × 16 − 8 ticks after the start edge. Under the macro, add 16 ticks.
- All status outputs are registered, 1 cycle wide, and mutually exclusive with `rx_done_tick`. The exception is `parity_err`, which coincides with `rx_done_tick`.
- Back-to-back frames are supported. IDLE can accept a new start edge on the cycle after the STOP decision.
- No backpressure exists. The consumer must accept `rx_done_tick` every cycle it is asserted, and FIFO overflow is the FIFO's concern.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - The `parity_err` port exists.
  - The frame is start + DBITS + even parity + stop.
- Macro undefined:
  - No PARITY state and no `parity_err` port.
  - The frame is 8N1 (DBITS data bits, no parity).

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `OVERSAMPLE = 16`;
  - `MID_TICK = 7`, `LAST_TICK = 15`.
- One sub-module, `sync_2ff`, is the generic 2-flop synchroniser, reused for any other asynchronous pin.
- Everything else stays flat: one state register plus counters.

## Test plan
- 8N1 frame 0x55, exactly 16 `s_tick`s per bit → one `rx_done_tick`, `dout` = 0x55, no error pulses.
- 0xA3 sent immediately followed by 0x3C, with no idle gap → two strobes, `dout` 0xA3 then 0x3C.
- Low glitch of 3 ticks on an idle line → no strobe, state returns to IDLE, a following 0x12 is received correctly.
- 0x7E sent with the stop bit forced low → `frame_err` = 1 for 1 cycle, no `rx_done_tick`, `dout` keeps its previous value.
- Line held low for 20 bit times, then released → exactly one `frame_err` + `break_det`, then no further pulses until the line is high and the next start edge arrives.
- `reset` asserted during data bit 4 of 0xF0 → no strobe; after release, 0x81 is received correctly.
- Under `UART_RX_PARITY_EN`: 0x03 sent with parity bit 1 → `rx_done_tick` + `parity_err`, `dout` = 0x03.
